y86_data_memory: RTL and testbench

Word-organised, single-port 64-bit data memory for the Y86 SEQ processor's memory stage. It accepts one read and/or one write per clock on a shared address and returns read data registered. It flags any access outside the implemented address range on `dmem_error` so the core can raise a memory-error status.

---
 rtl/y86_data_memory_if.sv | 28 ++
 rtl/y86_data_memory.sv | 69 ++++++
 tb/tb_y86_data_memory.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/y86_data_memory_if.sv
// y86_data_memory_if
//   Memory-stage bus between the Y86 SEQ core and its data memory.
//   addr        word address (full 64 bits, never truncated)
//   data        write data
//   we / re     write / read enable, sampled at the rising clock edge
//   q           registered read data
//   dmem_error  registered out-of-range access flag
//   master: the core side; slave: the memory side.
interface y86_data_memory_if #(
   parameter int WIDTH = 64
);
   logic [63:0]      addr;
   logic [WIDTH-1:0] data;
   logic             we;
   logic             re;
   logic [WIDTH-1:0] q;
   logic             dmem_error;

   modport master (
      output addr, data, we, re,
      input  q, dmem_error
   );

   modport slave (
      input  addr, data, we, re,
      output q, dmem_error
   );
endinterface

// File: rtl/y86_data_memory.sv
// y86_data_memory
//   Word-organised single-port data memory for the Y86 SEQ memory stage.
//   One read and/or one write per clock on a shared address; read data and
//   the out-of-range flag are registered and appear one edge after the access.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; clears q and dmem_error only,
//            the storage array keeps its contents
//     bus    y86_data_memory_if.slave (addr, data, we, re, q, dmem_error)
//   Parameters:
//     DEPTH  number of words, legal word addresses 0 .. DEPTH-1
//     WIDTH  data width (64 for the Y86 core)
module y86_data_memory #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   y86_data_memory_if.slave bus
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] DEPTH_W = 64'(DEPTH);

   // The whole 64-bit address takes part in the compare so that large
   // addresses never alias onto a legal word.
   function automatic logic addr_in_range(input logic [63:0] a);
      return a < DEPTH_W;
   endfunction

   // Storage powers up cleared; reset deliberately leaves it alone.
   logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

   logic             in_range_p0;
   logic             access_p0;
   logic [AW-1:0]    idx_p0;

   logic [WIDTH-1:0] q_p1;
   logic             err_p1;

   // ---- stage 0: address decode (combinational, same cycle as the access)
   assign in_range_p0 = addr_in_range(bus.addr);
   assign access_p0   = bus.we | bus.re;
   assign idx_p0      = bus.addr[AW-1:0];

   // ---- stage 0 -> 1: storage write and registered read
   // Out-of-range writes are dropped here, before they can touch any word.
   always_ff @(posedge clk) begin
      if (bus.we && in_range_p0)
         mem[idx_p0] <= bus.data;
   end

   // The read samples mem in the same edge as a write to the same word, so
   // it returns the old contents (read-before-write).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_p1   <= '0;
         err_p1 <= 1'b0;
      end else begin
         err_p1 <= access_p0 & ~in_range_p0;
         if (bus.re)
            q_p1 <= in_range_p0 ? mem[idx_p0] : '0;
      end
   end

   assign bus.q          = q_p1;
   assign bus.dmem_error = err_p1;

endmodule

// File: tb/tb_y86_data_memory.sv
module tb_y86_data_memory;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   y86_data_memory_if #(.WIDTH(64)) bus ();

   y86_data_memory #(.DEPTH(1024), .WIDTH(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic        we;
      logic        re;
      logic [63:0] addr;
      logic [63:0] data;
      logic [63:0] exp_q;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [63:0] q;
      logic        err;
      int          id;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // Drive one access before the edge, record what it should produce, then
   // compare just after the edge.
   task automatic apply(input vec_t v, input int id);
      exp_t e;
      @(negedge clk);
      bus.we   = v.we;
      bus.re   = v.re;
      bus.addr = v.addr;
      bus.data = v.data;
      sb.push_back('{q: v.exp_q, err: v.exp_err, id: id});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_empty: got 0 entries, required 1");
      end else begin
         e = sb.pop_front();
         check64($sformatf("q[%0d]", e.id), bus.q, e.q);
         check1($sformatf("err[%0d]", e.id), bus.dmem_error, e.err);
      end
   endtask

   initial begin
      vec_t v;
      localparam logic [63:0] V1  = 64'h1234567890ABCDEF;
      localparam logic [63:0] VF  = 64'hFFFFFFFFFFFFFFFF;
      localparam logic [63:0] VA  = 64'hA5A5A5A5A5A5A5A5;
      localparam logic [63:0] V55 = 64'h5555_0000_AAAA_0033;

      bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.data = '0;
      rst_n = 1'b0;
      #1;
      check64("reset_q_initial", bus.q, 64'h0);
      check1("reset_err_initial", bus.dmem_error, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Hand-written: make q and dmem_error nonzero, then reset without a clock.
      apply('{we:1, re:0, addr:3, data:V55, exp_q:0, exp_err:0}, 100);
      apply('{we:0, re:1, addr:3, data:0, exp_q:V55, exp_err:0}, 101);
      apply('{we:1, re:0, addr:64'd4096, data:64'h1, exp_q:V55, exp_err:1}, 102);
      #2;
      rst_n = 1'b0;
      #1;
      check64("async_reset_q", bus.q, 64'h0);
      check1("async_reset_err", bus.dmem_error, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      // Array survives reset; this read leaves q = V55 for the table below.
      apply('{we:0, re:1, addr:3, data:0, exp_q:V55, exp_err:0}, 103);

      // Table: {we, re, addr, data, expected q, expected dmem_error}
      vecs.push_back('{we:1, re:0, addr:5,       data:V1, exp_q:V55, exp_err:0});
      vecs.push_back('{we:0, re:0, addr:5,       data:0,  exp_q:V55, exp_err:0});
      vecs.push_back('{we:0, re:0, addr:5,       data:0,  exp_q:V55, exp_err:0});
      vecs.push_back('{we:0, re:1, addr:5,       data:0,  exp_q:V1,  exp_err:0});
      vecs.push_back('{we:0, re:0, addr:5,       data:0,  exp_q:V1,  exp_err:0});
      vecs.push_back('{we:1, re:1, addr:5,       data:VF, exp_q:V1,  exp_err:0});
      vecs.push_back('{we:0, re:1, addr:5,       data:0,  exp_q:VF,  exp_err:0});
      vecs.push_back('{we:1, re:0, addr:20,      data:VA, exp_q:VF,  exp_err:0});
      vecs.push_back('{we:0, re:1, addr:20,      data:0,  exp_q:VA,  exp_err:0});
      vecs.push_back('{we:0, re:1, addr:5,       data:0,  exp_q:VF,  exp_err:0});
      vecs.push_back('{we:1, re:0, addr:1024,    data:64'hDEAD, exp_q:VF, exp_err:1});
      vecs.push_back('{we:0, re:0, addr:1024,    data:0,  exp_q:VF,  exp_err:0});
      vecs.push_back('{we:0, re:1, addr:64'h8000000000000005, data:0, exp_q:0, exp_err:1});
      vecs.push_back('{we:0, re:1, addr:5,       data:0,  exp_q:VF,  exp_err:0});
      vecs.push_back('{we:0, re:1, addr:0,       data:0,  exp_q:0,   exp_err:0});
      vecs.push_back('{we:0, re:1, addr:20,      data:0,  exp_q:VA,  exp_err:0});
      vecs.push_back('{we:0, re:0, addr:2000,    data:0,  exp_q:VA,  exp_err:0});
      vecs.push_back('{we:0, re:0, addr:2000,    data:0,  exp_q:VA,  exp_err:0});
      // Boundary word: last legal address, untouched so far, then written.
      vecs.push_back('{we:0, re:1, addr:1023,    data:0,  exp_q:0,   exp_err:0});
      vecs.push_back('{we:1, re:0, addr:1023,    data:64'h77, exp_q:0, exp_err:0});
      vecs.push_back('{we:0, re:1, addr:1023,    data:0,  exp_q:64'h77, exp_err:0});
      // Out-of-range read+write together: q cleared, nothing stored.
      vecs.push_back('{we:1, re:1, addr:1024,    data:64'hBAD, exp_q:0, exp_err:1});
      vecs.push_back('{we:1, re:1, addr:64'h400, data:64'hBAD, exp_q:0, exp_err:1});
      vecs.push_back('{we:0, re:1, addr:0,       data:0,  exp_q:0,   exp_err:0});
      vecs.push_back('{we:0, re:1, addr:1023,    data:0,  exp_q:64'h77, exp_err:0});
      vecs.push_back('{we:0, re:1, addr:64'h10000000000003FF, data:0, exp_q:0, exp_err:1});
      vecs.push_back('{we:0, re:1, addr:1023,    data:0,  exp_q:64'h77, exp_err:0});

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         apply(v, i);
      end

      @(negedge clk);
      bus.we = 1'b0; bus.re = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach its end within the time limit");
      $fatal(1);
   end

endmodule
